// File: rtl/frame_averager_pkg.sv
// Shared types and defaults for the multi-frame averager.
// Holds the FSM state type and the accumulator width rule.
package frame_averager_pkg;

    localparam int FA_W_DEF      = 12;
    localparam int FA_FRAMES_DEF = 10;
    localparam int FA_POINTS_DEF = 10;

    typedef enum logic [2:0] {
        FA_IDLE  = 3'd0,
        FA_SUM   = 3'd1,
        FA_DIV   = 3'd2,
        FA_STORE = 3'd3,
        FA_DONE  = 3'd4
    } fa_state_t;

    // Wide enough for FRAMES full-scale samples plus the rounding preload.
    function automatic int fa_sum_w(input int w, input int frames);
        return w + $clog2(frames + 1);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, N iterations per division.
// `last` is high during the clock whose edge retires the final quotient bit.
module seq_divider #(
    parameter int N  = 16,
    parameter int QW = N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          flush,
    input  logic [N-1:0]  dividend,
    input  logic [N-1:0]  divisor,
    output logic [QW-1:0] quotient,
    output logic          last
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  div_q, div_d;
    logic [N:0]    rem_sh;
    logic          ge;

    always_comb begin
        rem_sh = {rem_q, quo_q[N-1]};
        ge     = (rem_sh >= {1'b0, div_q});
        run_d  = run_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        if (flush) begin
            run_d = 1'b0;
        end else if (start) begin
            run_d = 1'b1;
            cnt_d = CNT_LOAD;
            rem_d = '0;
            quo_d = dividend;
            div_d = divisor;
        end else if (run_q) begin
            // Quotient bits shift in from the bottom as dividend bits leave the top.
            rem_d = ge ? N'(rem_sh - {1'b0, div_q}) : rem_sh[N-1:0];
            quo_d = {quo_q[N-2:0], ge};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            div_q <= div_d;
        end
    end

    assign last     = run_q && (cnt_q == '0);
    assign quotient = quo_q[QW-1:0];

endmodule

// File: rtl/frame_averager.sv
// Per-point mean over FRAMES stored frames, one point at a time, result slots indexed by point.
// Define FRAME_AVERAGER_ROUND_EN for round-half-up instead of a truncating mean.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FA_IDLE  | waiting for start; outputs hold last results
// FA_SUM   | accumulating sample (f,p), one frame per clock
// FA_DIV   | sequential divide of the point sum by FRAMES
// FA_STORE | write quotient into slot p, advance to next point or finish
// FA_DONE  | done pulse visible, returning to idle
module frame_averager
    import frame_averager_pkg::*;
#(
    parameter int W      = FA_W_DEF,
    parameter int FRAMES = FA_FRAMES_DEF,
    parameter int POINTS = FA_POINTS_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [FRAMES*POINTS*W-1:0]   storage,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(POINTS+1)-1:0]  cnt_ratio,
    output logic [POINTS*W-1:0]          ratio,
    output logic [W-1:0]                 quotient
);

    localparam int SUM_W = fa_sum_w(W, FRAMES);
    localparam int FW    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int PW    = $clog2(POINTS + 1);

    localparam logic [FW-1:0]    F_LAST  = FW'(FRAMES - 1);
    localparam logic [PW-1:0]    P_LAST  = PW'(POINTS - 1);
    localparam logic [SUM_W-1:0] DIVISOR = SUM_W'(FRAMES);

`ifdef FRAME_AVERAGER_ROUND_EN
    localparam logic [SUM_W-1:0] ACC_INIT = SUM_W'(FRAMES / 2);
`else
    localparam logic [SUM_W-1:0] ACC_INIT = '0;
`endif

    fa_state_t         state_q, state_d;
    logic [FW-1:0]     f_q, f_d;
    logic [PW-1:0]     p_q, p_d;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [POINTS*W-1:0] ratio_q, ratio_d;
    logic [W-1:0]      quot_q, quot_d;

    logic [W-1:0]      sample;
    logic [SUM_W-1:0]  sum_next;
    logic              div_start;
    logic              div_last;
    logic [W-1:0]      div_quot;

    seq_divider #(
        .N  (SUM_W),
        .QW (W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .flush    (abort),
        .dividend (sum_next),
        .divisor  (DIVISOR),
        .quotient (div_quot),
        .last     (div_last)
    );

    always_comb begin
        sample    = storage[(int'(f_q) * POINTS + int'(p_q)) * W +: W];
        sum_next  = acc_q + SUM_W'(sample);
        state_d   = state_q;
        f_d       = f_q;
        p_d       = p_q;
        acc_d     = acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ratio_d   = ratio_q;
        quot_d    = quot_q;
        div_start = 1'b0;

        // Abort beats everything, including a start seen in the same cycle.
        if (abort) begin
            state_d = FA_IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                FA_IDLE: begin
                    if (start) begin
                        state_d = FA_SUM;
                        f_d     = '0;
                        p_d     = '0;
                        acc_d   = ACC_INIT;
                        busy_d  = 1'b1;
                    end
                end
                FA_SUM: begin
                    acc_d = sum_next;
                    f_d   = f_q + FW'(1);
                    if (f_q == F_LAST) begin
                        state_d   = FA_DIV;
                        div_start = 1'b1;
                    end
                end
                FA_DIV: begin
                    if (div_last) begin
                        state_d = FA_STORE;
                    end
                end
                FA_STORE: begin
                    ratio_d[int'(p_q) * W +: W] = div_quot;
                    quot_d = div_quot;
                    if (p_q == P_LAST) begin
                        state_d = FA_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FA_SUM;
                        p_d     = p_q + PW'(1);
                        f_d     = '0;
                        acc_d   = ACC_INIT;
                    end
                end
                FA_DONE: begin
                    state_d = FA_IDLE;
                end
                default: begin
                    state_d = FA_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FA_IDLE;
            f_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ratio_q <= '0;
            quot_q  <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ratio_q <= ratio_d;
            quot_q  <= quot_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cnt_ratio = p_q;
    assign ratio     = ratio_q;
    assign quotient  = quot_q;

endmodule

// File: tb/tb_frame_averager.sv
// Self-checking bench for frame_averager: cycle-level behavioural model plus directed literal checks.
// Honours FRAME_AVERAGER_ROUND_EN to select the expected rounding.
module tb_frame_averager;

    localparam int W      = 12;
    localparam int FRAMES = 10;
    localparam int POINTS = 10;
    localparam int SUM_W  = W + $clog2(FRAMES + 1);
    localparam int PER    = FRAMES + SUM_W + 1;
    localparam int RUN    = POINTS * PER;
    localparam int PW     = $clog2(POINTS + 1);
`ifdef FRAME_AVERAGER_ROUND_EN
    localparam int RND = FRAMES / 2;
`else
    localparam int RND = 0;
`endif

    logic                        clk;
    logic                        rst;
    logic                        start;
    logic                        abort;
    logic [FRAMES*POINTS*W-1:0]  storage;
    logic                        busy;
    logic                        done;
    logic [PW-1:0]               cnt_ratio;
    logic [POINTS*W-1:0]         ratio;
    logic [W-1:0]                quotient;

    frame_averager #(
        .W      (W),
        .FRAMES (FRAMES),
        .POINTS (POINTS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .storage   (storage),
        .busy      (busy),
        .done      (done),
        .cnt_ratio (cnt_ratio),
        .ratio     (ratio),
        .quotient  (quotient)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int get_s(input int f, input int p);
        return int'(storage[(f * POINTS + p) * W +: W]);
    endfunction

    task automatic set_s(input int f, input int p, input int v);
        storage[(f * POINTS + p) * W +: W] = W'(v);
    endtask

    function automatic int mean_pt(input int p);
        int s;
        s = RND;
        for (int f = 0; f < FRAMES; f++) s += get_s(f, p);
        return s / FRAMES;
    endfunction

    // Model: everything is a function of edges elapsed since the start was accepted.
    int                  cyc = 0;
    int                  m_t = 0;
    int                  m_start_cyc = 0;
    bit                  m_active = 0;
    logic                exp_busy = 0;
    logic                exp_done = 0;
    int                  exp_cnt = 0;
    logic [POINTS*W-1:0] exp_ratio = '0;
    logic [W-1:0]        exp_quot = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active  = 0;
            exp_busy  = 0;
            exp_done  = 0;
            exp_cnt   = 0;
            exp_ratio = '0;
            exp_quot  = '0;
        end else begin
            cyc++;
            if (m_active) begin
                m_t++;
                if (abort) begin
                    m_active = 0;
                    exp_busy = 0;
                    exp_done = 0;
                end else begin
                    if ((m_t % PER) == 0 && m_t <= RUN) begin
                        int p, v;
                        p = m_t / PER - 1;
                        v = mean_pt(p);
                        exp_ratio[p * W +: W] = W'(v);
                        exp_quot = W'(v);
                    end
                    exp_cnt  = (m_t / PER < POINTS) ? m_t / PER : POINTS - 1;
                    exp_busy = (m_t < RUN);
                    exp_done = (m_t == RUN);
                    if (m_t == RUN + 1) begin
                        m_active = 0;
                        exp_done = 0;
                    end
                end
            end else if (start && !abort) begin
                m_active    = 1;
                m_t         = 0;
                m_start_cyc = cyc;
                exp_busy    = 1;
                exp_cnt     = 0;
            end
        end
    end

    int n_done = 0;
    int done_rel = -1;

    always @(negedge clk) begin
        chk("busy", 128'(busy), 128'(exp_busy));
        chk("done", 128'(done), 128'(exp_done));
        chk("cnt_ratio", 128'(cnt_ratio), 128'(exp_cnt));
        chk("ratio", 128'(ratio), 128'(exp_ratio));
        chk("quotient", 128'(quotient), 128'(exp_quot));
        if (done === 1'b1) begin
            n_done++;
            done_rel = cyc - m_start_cyc;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start is sampled by the next edge; that edge is the reference edge 0.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_to_done(input string nm, input int n0);
        int k;
        k = 0;
        while (n_done == n0 && k < RUN + 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (n_done == n0) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", nm, RUN + 50);
        end
        wait_cycles(3);
    endtask

    task automatic fill_pattern1();
        for (int f = 0; f < FRAMES; f++)
            for (int p = 0; p < POINTS; p++) set_s(f, p, 100 * (p + 1));
    endtask

    task automatic fill_const(input int v);
        for (int f = 0; f < FRAMES; f++)
            for (int p = 0; p < POINTS; p++) set_s(f, p, v);
    endtask

    task automatic fill_random();
        for (int f = 0; f < FRAMES; f++)
            for (int p = 0; p < POINTS; p++) set_s(f, p, int'($urandom_range(0, (1 << W) - 1)));
    endtask

    task automatic chk_pattern1(input string nm);
        for (int p = 0; p < POINTS; p++)
            chk($sformatf("%s_slot%0d", nm, p), 128'(ratio[p * W +: W]), 128'(100 * (p + 1)));
    endtask

    initial begin
        int n0;
        int exp3;
        logic [POINTS*W-1:0] full;

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        storage = '0;
        #2;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_cnt", 128'(cnt_ratio), 128'(0));
        chk("rst_ratio", 128'(ratio), 128'(0));
        chk("rst_quot", 128'(quotient), 128'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(2);

        // Ramp pattern: done is visible after edge 270, i.e. sampled high at edge 271.
        fill_pattern1();
        n0 = n_done;
        pulse_start();
        run_to_done("s1", n0);
        chk_pattern1("s1");
        chk("s1_done_rel", 128'(done_rel), 128'(270));
        chk("s1_done_cnt", 128'(n_done - n0), 128'(1));
        chk("s1_quot", 128'(quotient), 128'(1000));

        // Full scale: no wrap in the accumulator.
        fill_const((1 << W) - 1);
        n0 = n_done;
        pulse_start();
        run_to_done("s2", n0);
        full = {POINTS{12'hFFF}};
        chk("s2_ratio", 128'(ratio), 128'(full));

        // Rounding boundary: sum 15 and sum 14 at point 0.
`ifdef FRAME_AVERAGER_ROUND_EN
        exp3 = 2;
`else
        exp3 = 1;
`endif
        fill_random();
        for (int f = 0; f < FRAMES; f++) set_s(f, 0, (f < 5) ? 3 : 0);
        n0 = n_done;
        pulse_start();
        run_to_done("s3a", n0);
        chk("s3a_slot0", 128'(ratio[W-1:0]), 128'(exp3));
        set_s(4, 0, 2);
        n0 = n_done;
        pulse_start();
        run_to_done("s3b", n0);
        chk("s3b_slot0", 128'(ratio[W-1:0]), 128'(1));

        // Start re-pulsed at edges 5 and 200 while busy is ignored.
        fill_pattern1();
        n0 = n_done;
        pulse_start();
        wait_cycles(4);
        pulse_start();
        wait_cycles(194);
        pulse_start();
        run_to_done("s4", n0);
        chk("s4_done_cnt", 128'(n_done - n0), 128'(1));
        chk("s4_done_rel", 128'(done_rel), 128'(270));
        chk_pattern1("s4");

        // Reset mid-run at edge 100 clears everything immediately.
        fill_random();
        n0 = n_done;
        pulse_start();
        wait_cycles(99);
        rst = 1'b1;
        #1;
        chk("s5_busy", 128'(busy), 128'(0));
        chk("s5_done", 128'(done), 128'(0));
        chk("s5_cnt", 128'(cnt_ratio), 128'(0));
        chk("s5_ratio", 128'(ratio), 128'(0));
        chk("s5_quot", 128'(quotient), 128'(0));
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(5);
        chk("s5_no_done", 128'(n_done - n0), 128'(0));
        fill_pattern1();
        n0 = n_done;
        pulse_start();
        run_to_done("s5", n0);
        chk("s5_done_rel", 128'(done_rel), 128'(270));
        chk_pattern1("s5");

        // Abort at edge 50 after priming every slot with 0xABC.
        fill_const(12'hABC);
        n0 = n_done;
        pulse_start();
        run_to_done("s6p", n0);
        fill_pattern1();
        n0 = n_done;
        pulse_start();
        wait_cycles(49);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("s6_busy", 128'(busy), 128'(0));
        wait_cycles(300);
        chk("s6_no_done", 128'(n_done - n0), 128'(0));
        chk("s6_slot0", 128'(ratio[W-1:0]), 128'(100));
        chk("s6_slot1", 128'(ratio[2*W-1:W]), 128'(12'hABC));
        chk("s6_slot9", 128'(ratio[POINTS*W-1 -: W]), 128'(12'hABC));

        // Random data, with one random abort thrown in.
        for (int r = 0; r < 4; r++) begin
            fill_random();
            n0 = n_done;
            pulse_start();
            if (r == 2) begin
                wait_cycles(int'($urandom_range(1, RUN - 5)));
                abort = 1'b1;
                @(posedge clk);
                #1 abort = 1'b0;
                wait_cycles(RUN + 10);
            end else begin
                run_to_done($sformatf("rnd%0d", r), n0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
